// File: rtl/dp_app_ram_ldr_if.sv
// Stream-in / RAM-init-out bundle for the application RAM boot loader.
// The loader connects through the slave modport; the byte source uses master.
interface dp_app_ram_ldr_if;
  logic [7:0]  S_DAT_IN;
  logic        S_VLD_IN;
  logic        S_RDY_OUT;
  logic        INIT_STR_OUT;
  logic [31:0] INIT_DAT_OUT;
  logic        INIT_VLD_OUT;
  logic        BUSY_OUT;
  logic        DONE_OUT;
  logic        ERR_OUT;
  logic [1:0]  ERR_CODE_OUT;

  modport master (
    output S_DAT_IN,
    output S_VLD_IN,
    input  S_RDY_OUT,
    input  INIT_STR_OUT,
    input  INIT_DAT_OUT,
    input  INIT_VLD_OUT,
    input  BUSY_OUT,
    input  DONE_OUT,
    input  ERR_OUT,
    input  ERR_CODE_OUT
  );

  modport slave (
    input  S_DAT_IN,
    input  S_VLD_IN,
    output S_RDY_OUT,
    output INIT_STR_OUT,
    output INIT_DAT_OUT,
    output INIT_VLD_OUT,
    output BUSY_OUT,
    output DONE_OUT,
    output ERR_OUT,
    output ERR_CODE_OUT
  );
endinterface

// File: rtl/dp_app_ram_ldr.sv
// Boot loader: parses A5/LEN/DATA/CHK frames into little-endian 32-bit RAM init writes,
// checking length, checksum and inter-byte timeout, and reporting sticky load status.
module dp_app_ram_ldr #(
  parameter int unsigned P_ADR = 10,
  parameter int unsigned P_TO  = 65535
) (
  input logic             CLK_IN,
  input logic             RST_IN,
  dp_app_ram_ldr_if.slave ldr
);

  localparam int unsigned Cap = 2 ** (P_ADR - 2);
  localparam int unsigned ToW = $clog2(P_TO);

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e       state;
  logic [7:0]   len_lo;
  logic [15:0]  wcnt;
  logic [1:0]   bcnt;
  logic [23:0]  word_buf;
  logic [7:0]   chk;
  logic [ToW-1:0] to_cnt;

  logic         rdy;
  logic         init_str;
  logic [31:0]  init_dat;
  logic         init_vld;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   err_code;

  logic         acc;
  logic         in_frame;
  logic         to_hit;
  logic [15:0]  len_full;
  logic [7:0]   chk_sum;

  assign acc      = ldr.S_VLD_IN & rdy;
  assign in_frame = (state == StLen0) || (state == StLen1) || (state == StData) ||
                    (state == StChk);
  // Fires on the P_TO-th consecutive idle cycle inside a frame.
  assign to_hit   = !acc && (to_cnt == ToW'(P_TO - 1));
  assign len_full = {ldr.S_DAT_IN, len_lo};
  assign chk_sum  = chk + ldr.S_DAT_IN;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state    <= StIdle;
      len_lo   <= '0;
      wcnt     <= '0;
      bcnt     <= '0;
      word_buf <= '0;
      chk      <= '0;
      to_cnt   <= '0;
      rdy      <= 1'b0;
      init_str <= 1'b0;
      init_dat <= '0;
      init_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      rdy      <= 1'b1;
      init_str <= 1'b0;
      init_vld <= 1'b0;

      if (in_frame && !acc) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end

      unique case (state)
        StIdle, StDone, StErr: begin
          if (acc && (ldr.S_DAT_IN == 8'hA5)) begin
            state    <= StLen0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            busy     <= 1'b1;
            chk      <= '0;
          end
        end

        StLen0: begin
          if (to_hit) begin
            state    <= StErr;
            err      <= 1'b1;
            err_code <= 2'd3;
            busy     <= 1'b0;
          end else if (acc) begin
            len_lo <= ldr.S_DAT_IN;
            state  <= StLen1;
          end
        end

        StLen1: begin
          if (to_hit) begin
            state    <= StErr;
            err      <= 1'b1;
            err_code <= 2'd3;
            busy     <= 1'b0;
          end else if (acc) begin
            if ((len_full == 16'd0) || (32'(len_full) > Cap)) begin
              state    <= StErr;
              err      <= 1'b1;
              err_code <= 2'd1;
              busy     <= 1'b0;
            end else begin
              wcnt     <= len_full;
              bcnt     <= 2'd0;
              init_str <= 1'b1;
              state    <= StData;
            end
          end
        end

        StData: begin
          if (to_hit) begin
            // Any partially assembled word is simply dropped.
            state    <= StErr;
            err      <= 1'b1;
            err_code <= 2'd3;
            busy     <= 1'b0;
          end else if (acc) begin
            chk  <= chk_sum;
            bcnt <= bcnt + 1'b1;
            unique case (bcnt)
              2'd0: word_buf[7:0]   <= ldr.S_DAT_IN;
              2'd1: word_buf[15:8]  <= ldr.S_DAT_IN;
              2'd2: word_buf[23:16] <= ldr.S_DAT_IN;
              2'd3: begin
                init_dat <= {ldr.S_DAT_IN, word_buf};
                init_vld <= 1'b1;
                wcnt     <= wcnt - 1'b1;
                if (wcnt == 16'd1) begin
                  state <= StChk;
                end
              end
            endcase
          end
        end

        StChk: begin
          if (to_hit) begin
            state    <= StErr;
            err      <= 1'b1;
            err_code <= 2'd3;
            busy     <= 1'b0;
          end else if (acc) begin
            busy <= 1'b0;
            if (chk_sum == 8'd0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state    <= StErr;
              err      <= 1'b1;
              err_code <= 2'd2;
            end
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

  assign ldr.S_RDY_OUT    = rdy;
  assign ldr.INIT_STR_OUT = init_str;
  assign ldr.INIT_DAT_OUT = init_dat;
  assign ldr.INIT_VLD_OUT = init_vld;
  assign ldr.BUSY_OUT     = busy;
  assign ldr.DONE_OUT     = done;
  assign ldr.ERR_OUT      = err;
  assign ldr.ERR_CODE_OUT = err_code;

endmodule

// File: tb/tb_dp_app_ram_ldr.sv
// Scoreboard bench for dp_app_ram_ldr: a frame-level model queues expected RAM writes and
// final status; a monitor pops and compares every INIT_STR/INIT_VLD pulse.
module tb_dp_app_ram_ldr;
  localparam int unsigned PAdr = 10;
  localparam int unsigned PTo  = 16;
  localparam int          Cap  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dp_app_ram_ldr_if bus ();

  dp_app_ram_ldr #(
    .P_ADR(PAdr),
    .P_TO (PTo)
  ) dut (
    .CLK_IN(clk),
    .RST_IN(rst),
    .ldr   (bus)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        is_str;
    logic [31:0] dat;
  } ev_t;

  ev_t         exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] last_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Expected writes and final status of one frame (sync byte first), from the frame rules.
  function automatic void model(input bq_t fr, output logic ed, output logic ee,
                                output logic [1:0] ec);
    int         len;
    int         ndata;
    logic [7:0] sum;
    ev_t        ev;
    ed  = 1'b0;
    ee  = 1'b0;
    ec  = 2'd0;
    len = int'(fr[1]) + 256 * int'(fr[2]);
    if (len == 0 || len > Cap) begin
      ee = 1'b1;
      ec = 2'd1;
      return;
    end
    ev.is_str = 1'b1;
    ev.dat    = '0;
    exp_q.push_back(ev);
    ndata = fr.size() - 3;
    if (ndata > 4 * len) ndata = 4 * len;
    sum = 8'd0;
    for (int i = 0; i < ndata; i++) sum += fr[3+i];
    for (int w = 0; 4 * w + 4 <= ndata; w++) begin
      ev.is_str = 1'b0;
      ev.dat    = {fr[3+4*w+3], fr[3+4*w+2], fr[3+4*w+1], fr[3+4*w]};
      exp_q.push_back(ev);
    end
    if (fr.size() == 4 * len + 4) begin
      sum += fr[4*len+3];
      if (sum == 8'd0) ed = 1'b1;
      else begin
        ee = 1'b1;
        ec = 2'd2;
      end
    end else begin
      ee = 1'b1;
      ec = 2'd3;
    end
  endfunction

  function automatic bq_t make_frame(input int len, input bit good);
    bq_t        f;
    logic [7:0] b;
    logic [7:0] sum;
    logic [15:0] l16;
    l16 = 16'(len);
    sum = 8'd0;
    f.push_back(8'hA5);
    f.push_back(l16[7:0]);
    f.push_back(l16[15:8]);
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'($urandom_range(0, 255));
      sum += b;
      f.push_back(b);
    end
    if (good) f.push_back(8'd0 - sum);
    else f.push_back(8'd0 - sum + 8'($urandom_range(1, 255)));
    return f;
  endfunction

  // Monitor: every pulse must match the head of the scoreboard.
  initial begin
    ev_t ev;
    last_dat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_dat = '0;
      end else begin
        check("str_vld_overlap", 32'(bus.INIT_STR_OUT & bus.INIT_VLD_OUT), 32'd0);
        if (bus.INIT_STR_OUT || bus.INIT_VLD_OUT) begin
          if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_write: str=%0b vld=%0b dat=0x%08h, required no write",
                     bus.INIT_STR_OUT, bus.INIT_VLD_OUT, bus.INIT_DAT_OUT);
          end else begin
            ev = exp_q.pop_front();
            check("write_kind_str", 32'(bus.INIT_STR_OUT), 32'(ev.is_str));
            if (!ev.is_str) begin
              check("write_data", bus.INIT_DAT_OUT, ev.dat);
              last_dat = ev.dat;
            end
          end
        end else begin
          check("init_dat_hold", bus.INIT_DAT_OUT, last_dat);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      bus.S_VLD_IN = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    bus.S_DAT_IN = b;
    bus.S_VLD_IN = 1'b1;
    @(posedge clk);
    #1;
    bus.S_VLD_IN = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic ed, input logic ee,
                              input logic [1:0] ec);
    check({tag, "_done"}, 32'(bus.DONE_OUT), 32'(ed));
    check({tag, "_err"}, 32'(bus.ERR_OUT), 32'(ee));
    check({tag, "_code"}, 32'(bus.ERR_CODE_OUT), 32'(ec));
    check({tag, "_busy"}, 32'(bus.BUSY_OUT), 32'd0);
  endtask

  task automatic run_frame(input string tag, input bq_t junk, input bq_t fr, input int maxgap);
    logic       ed;
    logic       ee;
    logic [1:0] ec;
    int         n;
    model(fr, ed, ee, ec);
    foreach (junk[i]) send_byte(junk[i], $urandom_range(0, maxgap));
    foreach (fr[i]) send_byte(fr[i], (i == 0) ? 0 : $urandom_range(0, maxgap));
    n = 0;
    @(negedge clk);
    while (bus.BUSY_OUT && n < PTo + 20) begin
      @(negedge clk);
      n++;
    end
    check_status(tag, ed, ee, ec);
    repeat (3) @(negedge clk);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdy"}, 32'(bus.S_RDY_OUT), 32'd0);
    check({tag, "_str"}, 32'(bus.INIT_STR_OUT), 32'd0);
    check({tag, "_dat"}, bus.INIT_DAT_OUT, 32'd0);
    check({tag, "_vld"}, 32'(bus.INIT_VLD_OUT), 32'd0);
    check({tag, "_busy"}, 32'(bus.BUSY_OUT), 32'd0);
    check({tag, "_done"}, 32'(bus.DONE_OUT), 32'd0);
    check({tag, "_err"}, 32'(bus.ERR_OUT), 32'd0);
    check({tag, "_code"}, 32'(bus.ERR_CODE_OUT), 32'd0);
  endtask

  initial begin
    bq_t        none;
    bq_t        junk;
    bq_t        t1;
    bq_t        fr;
    logic       ed;
    logic       ee;
    logic [1:0] ec;

    bus.S_DAT_IN = 8'h00;
    bus.S_VLD_IN = 1'b0;
    none = {};
    t1 = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h9C};

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rdy_after_reset", 32'(bus.S_RDY_OUT), 32'd1);

    run_frame("t1", none, t1, 0);

    fr = t1;
    fr[11] = 8'h9D;
    run_frame("t2_badchk", none, fr, 0);

    run_frame("t3_len0", none, '{8'hA5, 8'h00, 8'h00}, 0);
    run_frame("t3_len257", none, '{8'hA5, 8'h01, 8'h01}, 0);

    // Timeout must fire on exactly the 16th idle cycle.
    fr = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    model(fr, ed, ee, ec);
    foreach (fr[i]) send_byte(fr[i], 0);
    repeat (16) @(negedge clk);
    check("t4_busy_before_to", 32'(bus.BUSY_OUT), 32'd1);
    @(negedge clk);
    check_status("t4_timeout", ed, ee, ec);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    run_frame("t4_after", none, '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6}, 0);

    run_frame("t5_junk_gaps", '{8'h00, 8'hFF, 8'h3C}, t1, 5);

    // Reset after the fifth data byte of frame 1.
    fr = {};
    for (int i = 0; i < 8; i++) fr.push_back(t1[i]);
    model(fr, ed, ee, ec);
    foreach (fr[i]) send_byte(fr[i], 0);
    rst = 1'b1;
    #1;
    check_zero("t6_reset");
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_frame("t6_fresh", none, t1, 2);

    run_frame("cap_256", none, make_frame(Cap, 1'b1), 0);

    for (int k = 0; k < 8; k++) begin
      junk = {};
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        junk.push_back(8'($urandom_range(0, 255)));
        if (junk[j] == 8'hA5) junk[j] = 8'h3C;
      end
      run_frame("rand", junk, make_frame(int'($urandom_range(1, 6)), ($urandom_range(0, 3) != 0)),
                int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
